// File: rtl/dma_write_sequencer_if.sv
// Request stream and write-master handshake bundle for dma_write_sequencer.
// slave = the sequencer's view; master = request source plus write-master side.
interface dma_write_sequencer_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_address;
   logic [DATA_WIDTH-1:0] in_data;
   logic [ADDR_WIDTH-1:0] dma_address;
   logic [DATA_WIDTH-1:0] dma_data;
   logic                  dma_init;
   logic                  dma_done;

   modport slave (
      input  in_valid, in_address, in_data, dma_done,
      output in_ready, dma_address, dma_data, dma_init
   );

   modport master (
      output in_valid, in_address, in_data, dma_done,
      input  in_ready, dma_address, dma_data, dma_init
   );
endinterface

// File: rtl/dma_write_sequencer.sv
// Request FIFO plus one-at-a-time issue sequencer for a single-beat write master.
// Optional watchdog (sticky timeout_error, terminal HALT) enabled by DMA_SEQ_TIMEOUT_EN.
module dma_write_sequencer #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int FIFO_DEPTH     = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                        clock,
   input  logic                        reset,
   dma_write_sequencer_if.slave        bus,
   output logic                        busy,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic [31:0]                 completed_count,
   output logic                        timeout_error
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_DONE,
      COOLDOWN,
      HALT
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
   logic [PTR_W:0]        wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH-1:0] dma_address_q;
   logic [DATA_WIDTH-1:0] dma_data_q;
   logic [31:0]           completed_q;
   logic                  full_w, empty_w, push_w, pop_w, load_w, done_w, expire_w;

   // Extra wrap bit on each pointer distinguishes full from empty.
   assign full_w  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                    (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign empty_w = (wr_ptr_q == rd_ptr_q);

   assign bus.in_ready = !full_w && !reset;
   assign push_w       = bus.in_valid && bus.in_ready;
   assign pop_w        = (state_q == ISSUE);
   // Operands are loaded on the edge entering ISSUE so they are valid alongside dma_init.
   assign load_w       = (state_d == ISSUE);

   always_ff @(posedge clock) begin
      if (push_w) begin
         addr_mem[wr_ptr_q[PTR_W-1:0]] <= bus.in_address;
         data_mem[wr_ptr_q[PTR_W-1:0]] <= bus.in_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         state_q     <= IDLE;
         completed_q <= '0;
      end else begin
         state_q <= state_d;
         if (push_w) begin
            wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
         end
         if (pop_w) begin
            rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
         end
         if (done_w) begin
            completed_q <= completed_q + 32'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         dma_address_q <= '0;
         dma_data_q    <= '0;
      end else if (load_w) begin
         dma_address_q <= addr_mem[rd_ptr_q[PTR_W-1:0]];
         dma_data_q    <= data_mem[rd_ptr_q[PTR_W-1:0]];
      end
   end

`ifdef DMA_SEQ_TIMEOUT_EN
   logic [31:0] wd_q;
   logic        timeout_q;

   assign expire_w = (state_q == WAIT_DONE) && !bus.dma_done &&
                     (wd_q == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock) begin
      if (reset) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_q == ISSUE) begin
            wd_q <= '0;
         end else if (state_q == WAIT_DONE) begin
            wd_q <= wd_q + 32'd1;
         end
         if (expire_w) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_error = timeout_q;
`else
   logic [31:0] unused_timeout;

   assign unused_timeout = 32'(TIMEOUT_CYCLES);
   assign expire_w       = 1'b0;
   assign timeout_error  = 1'b0;
`endif

   // A done level still high from before reset blocks issue until it drops.
   always_comb begin
      state_d = state_q;
      done_w  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty_w && !bus.dma_done) begin
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (bus.dma_done) begin
               done_w  = 1'b1;
               state_d = COOLDOWN;
            end else if (expire_w) begin
               state_d = HALT;
            end
         end
         COOLDOWN: begin
            if (!bus.dma_done) begin
               state_d = empty_w ? IDLE : ISSUE;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.dma_address = dma_address_q;
   assign bus.dma_data    = dma_data_q;
   assign bus.dma_init    = (state_q == ISSUE);

   assign busy            = (state_q != IDLE) || !empty_w;
   assign fifo_level      = wr_ptr_q - rd_ptr_q;
   assign completed_count = completed_q;
endmodule

// File: tb/tb_dma_write_sequencer.sv
// Directed bench for dma_write_sequencer with a write-master responder model.
// Watchdog scenario runs only when DMA_SEQ_TIMEOUT_EN is defined (TIMEOUT_CYCLES=20).
module tb_dma_write_sequencer;
   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 16;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clock = 1'b0;
   logic          reset;
   logic          busy;
   logic [LW-1:0] fifo_level;
   logic [31:0]   completed_count;
   logic          timeout_error;

   dma_write_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   dma_write_sequencer #(
      .ADDR_WIDTH    (AW),
      .DATA_WIDTH    (DW),
      .FIFO_DEPTH    (DEPTH),
      .TIMEOUT_CYCLES(20)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .bus            (bus),
      .busy           (busy),
      .fifo_level     (fifo_level),
      .completed_count(completed_count),
      .timeout_error  (timeout_error)
   );

   always #5 clock = ~clock;

   int          checks   = 0;
   int          failures = 0;
   int          done_delay = 4;
   int          done_hold  = 2;
   logic        resp_done  = 1'b0;
   logic        stale_done = 1'b0;
   logic        resp_abort = 1'b0;
   int          init_count = 0;
   logic [31:0] iss_addr [$];
   logic [31:0] iss_data [$];

   assign bus.dma_done = resp_done | stale_done;

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   always @(posedge clock) begin
      if (bus.dma_init === 1'b1) begin
         init_count <= init_count + 1;
      end
   end

   // Write-master model: after dma_init waits done_delay cycles, raises done for done_hold.
   initial begin : write_master_model
      logic [31:0] cap_a;
      logic [31:0] cap_d;
      forever begin
         @(negedge clock);
         if (bus.dma_init === 1'b1 && !resp_abort) begin
            cap_a = bus.dma_address;
            cap_d = bus.dma_data;
            iss_addr.push_back(cap_a);
            iss_data.push_back(cap_d);
            $display("issue addr=0x%08h data=0x%08h level=%0d", cap_a, cap_d, fifo_level);
            for (int i = 0; i < done_delay; i++) begin
               @(negedge clock);
               if (resp_abort) break;
               check_value("wait_addr_stable", bus.dma_address, cap_a);
               check_value("wait_data_stable", bus.dma_data, cap_d);
               check_value("wait_no_init", bus.dma_init, 1'b0);
            end
            if (!resp_abort) begin
               resp_done = 1'b1;
               for (int i = 0; i < done_hold; i++) begin
                  @(negedge clock);
                  if (resp_abort) break;
                  check_value("done_addr_stable", bus.dma_address, cap_a);
                  check_value("done_no_init", bus.dma_init, 1'b0);
                  check_value("done_busy", busy, 1'b1);
               end
            end
            resp_done = 1'b0;
         end
      end
   end

   initial begin : global_watchdog
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   task automatic push(input logic [31:0] a, input logic [31:0] d);
      int guard = 0;
      bus.in_valid   = 1'b1;
      bus.in_address = a;
      bus.in_data    = d;
      while (bus.in_ready !== 1'b1 && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      check_value("push_ready", bus.in_ready, 1'b1);
      @(negedge clock);
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy !== 1'b0 || bus.dma_done !== 1'b0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      check_value("idle_reached", busy, 1'b0);
   endtask

   task automatic clear_log();
      iss_addr.delete();
      iss_data.delete();
   endtask

   initial begin : main
      int base_cnt;
      int base_init;
      int n;

      reset          = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_address = '0;
      bus.in_data    = '0;
      repeat (3) @(negedge clock);
      check_value("rst_ready", bus.in_ready, 1'b0);
      check_value("rst_init", bus.dma_init, 1'b0);
      check_value("rst_addr", bus.dma_address, 32'h0);
      check_value("rst_data", bus.dma_data, 32'h0);
      check_value("rst_busy", busy, 1'b0);
      check_value("rst_level", fifo_level, 0);
      check_value("rst_count", completed_count, 0);
      check_value("rst_timeout", timeout_error, 1'b0);
      reset = 1'b0;
      @(negedge clock);
      check_value("ready_after_reset", bus.in_ready, 1'b1);

      // Single request
      done_delay = 4;
      done_hold  = 2;
      clear_log();
      base_init = init_count;
      push(32'h43C0_0000, 32'hDEAD_BEEF);
      wait_idle(100);
      check_value("single_inits", init_count - base_init, 1);
      check_value("single_count", completed_count, 1);
      check_value("single_addr", iss_addr[0], 32'h43C0_0000);
      check_value("single_data", iss_data[0], 32'hDEAD_BEEF);

      // Burst of 16 with issue held off by a high done level until the FIFO is full
      done_delay = 2;
      done_hold  = 1;
      clear_log();
      base_init  = init_count;
      base_cnt   = completed_count;
      stale_done = 1'b1;
      for (int i = 0; i < 16; i++) begin
         push(32'h1000_0000 + 32'(i * 4), 32'hA5A5_0000 + 32'(i));
      end
      check_value("burst_level_full", fifo_level, 16);
      check_value("burst_ready_low", bus.in_ready, 1'b0);
      check_value("burst_no_early_init", init_count - base_init, 0);
      stale_done = 1'b0;
      wait_idle(600);
      check_value("burst_inits", init_count - base_init, 16);
      check_value("burst_count", completed_count - base_cnt, 16);
      check_value("burst_level_empty", fifo_level, 0);
      for (int i = 0; i < 16; i++) begin
         check_value("burst_addr", iss_addr[i], 32'h1000_0000 + 32'(i * 4));
         check_value("burst_data", iss_data[i], 32'hA5A5_0000 + 32'(i));
      end

      // Long done hold, then done already high on WAIT_DONE's first cycle
      for (int pass = 0; pass < 2; pass++) begin
         done_delay = (pass == 0) ? 1 : 0;
         done_hold  = (pass == 0) ? 10 : 3;
         clear_log();
         base_init = init_count;
         base_cnt  = completed_count;
         push(32'h5000_0000 + 32'(pass), 32'h1111_0000);
         push(32'h5000_0100 + 32'(pass), 32'h2222_0000);
         wait_idle(200);
         check_value("hold_inits", init_count - base_init, 2);
         check_value("hold_count", completed_count - base_cnt, 2);
         check_value("hold_addr0", iss_addr[0], 32'h5000_0000 + 32'(pass));
         check_value("hold_addr1", iss_addr[1], 32'h5000_0100 + 32'(pass));
      end

      // Push in the ISSUE cycle with three queued: level stays 3
      done_delay = 4;
      done_hold  = 2;
      clear_log();
      stale_done = 1'b1;
      for (int i = 0; i < 3; i++) begin
         push(32'h2000_0000 + 32'(i), 32'h0000_00B0 + 32'(i));
      end
      check_value("sim_level_pre", fifo_level, 3);
      stale_done = 1'b0;
      @(negedge clock);
      check_value("sim_init", bus.dma_init, 1'b1);
      check_value("sim_level_issue", fifo_level, 3);
      push(32'h2000_0003, 32'h0000_00B3);
      check_value("sim_level_post", fifo_level, 3);
      wait_idle(200);
      for (int i = 0; i < 4; i++) begin
         check_value("sim_order_addr", iss_addr[i], 32'h2000_0000 + 32'(i));
         check_value("sim_order_data", iss_data[i], 32'h0000_00B0 + 32'(i));
      end

      // Reset during WAIT_DONE with five queued and a stale done level afterwards
      done_delay = 100;
      done_hold  = 1;
      clear_log();
      stale_done = 1'b1;
      for (int i = 0; i < 6; i++) begin
         push(32'h7000_0000 + 32'(i), 32'h7700_0000 + 32'(i));
      end
      base_init  = init_count;
      stale_done = 1'b0;
      repeat (3) @(negedge clock);
      check_value("mid_level", fifo_level, 5);
      check_value("mid_busy", busy, 1'b1);
      check_value("mid_inits", init_count - base_init, 1);
      resp_abort = 1'b1;
      @(negedge clock);
      stale_done = 1'b1;
      reset      = 1'b1;
      @(negedge clock);
      check_value("mid_rst_ready", bus.in_ready, 1'b0);
      check_value("mid_rst_addr", bus.dma_address, 32'h0);
      check_value("mid_rst_data", bus.dma_data, 32'h0);
      check_value("mid_rst_level", fifo_level, 0);
      check_value("mid_rst_busy", busy, 1'b0);
      check_value("mid_rst_count", completed_count, 0);
      reset = 1'b0;
      base_init = init_count;
      repeat (5) @(negedge clock);
      check_value("stale_no_init", init_count - base_init, 0);
      check_value("stale_busy", busy, 1'b0);
      resp_abort = 1'b0;
      done_delay = 3;
      clear_log();
      push(32'h3000_0040, 32'hC0FF_EE00);
      repeat (3) @(negedge clock);
      check_value("stale_hold_off", init_count - base_init, 0);
      check_value("stale_level", fifo_level, 1);
      stale_done = 1'b0;
      wait_idle(100);
      check_value("post_rst_count", completed_count, 1);
      check_value("post_rst_addr", iss_addr[0], 32'h3000_0040);
      check_value("post_rst_data", iss_data[0], 32'hC0FF_EE00);

`ifdef DMA_SEQ_TIMEOUT_EN
      // Watchdog: ISSUE in cycle N, counter 0..19 over WAIT_DONE cycles N+1..N+20,
      // flag registered at the end of N+20 and seen on the following sample.
      done_delay = 1000;
      clear_log();
      stale_done = 1'b1;
      push(32'h6000_0000, 32'h6666_0000);
      push(32'h6000_0004, 32'h6666_0004);
      base_init  = init_count;
      stale_done = 1'b0;
      n = 0;
      while (bus.dma_init !== 1'b1 && n < 20) begin
         @(negedge clock);
         n++;
      end
      check_value("to_issue", bus.dma_init, 1'b1);
      n = 0;
      while (timeout_error !== 1'b1 && n < 40) begin
         @(negedge clock);
         n++;
      end
      check_value("to_latency", n, 21);
      repeat (30) @(negedge clock);
      check_value("to_no_init", init_count - base_init, 1);
      check_value("to_sticky", timeout_error, 1'b1);
      check_value("to_busy", busy, 1'b1);
      check_value("to_level", fifo_level, 1);
      push(32'h6000_0008, 32'h6666_0008);
      check_value("to_push_level", fifo_level, 2);
      resp_abort = 1'b1;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check_value("to_rst_clear", timeout_error, 1'b0);
      check_value("to_rst_busy", busy, 1'b0);
      reset      = 1'b0;
      resp_abort = 1'b0;
      @(negedge clock);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dma_write_sequencer.md
Name: dma_write_sequencer

Overview:
- Upstream feeder for the single-beat AXI4-Lite write master (DMA manager instance).
- Buffers (address, data) write requests arriving on a valid/ready stream in a FIFO.
- Issues the requests to the write master one at a time: one-cycle start pulse, operands held stable, then a wait for the master's done level and its release before the next request.

Parameters:
- ADDR_WIDTH, 32, width of write address
- DATA_WIDTH, 32, width of write data
- FIFO_DEPTH, 16, request FIFO entries; power of 2, ≥2
- TIMEOUT_CYCLES, 1024, watchdog limit in clocks (used only with the optional feature)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  FIFO can accept; equals !full
- in_address  in  ADDR_WIDTH  request address
- in_data  in  DATA_WIDTH  request data
- dma_address  out  ADDR_WIDTH  address presented to the write master
- dma_data  out  DATA_WIDTH  data presented to the write master
- dma_init  out  1  one-cycle start pulse to the write master
- dma_done  in  1  write-master done level
- busy  out  1  high whenever state != IDLE or FIFO not empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- completed_count  out  32  writes completed since reset; wraps at 2^32
- timeout_error  out  1  sticky watchdog flag (tied 0 when feature absent)

Behaviour:
- Reset values:
  - in_ready=0 during reset, 1 the cycle after.
  - dma_address=0, dma_data=0, dma_init=0, busy=0, fifo_level=0, completed_count=0, timeout_error=0.
  - FIFO pointers cleared; state=IDLE.
- Reset mid-transaction: FIFO contents discarded. An outstanding downstream write is not tracked; a dma_done level seen after reset is ignored until it deasserts (state COOLDOWN is not entered; IDLE requires dma_done=0 to issue).
- Push: accepted when in_valid && in_ready. Entry visible to the pop logic on the next cycle (1-cycle minimum latency, push to ISSUE).
- Full: in_ready=0 and no push. Empty: no pop.
- Same-cycle push and pop: level unchanged.
- Pointers: log2(FIFO_DEPTH) bits plus a wrap bit; full/empty derived from pointer compare.
- State machine:
  - IDLE: if FIFO not empty && dma_done==0 -> ISSUE.
  - ISSUE (1 cycle):
    - Pop head.
    - Register head into dma_address/dma_data.
    - Assert dma_init for exactly this one cycle, with operands valid the same cycle.
    - -> WAIT_DONE.
  - WAIT_DONE:
    - dma_address/dma_data held constant.
    - On dma_done==1: completed_count+1 -> COOLDOWN.
  - COOLDOWN: wait for dma_done==0. Then -> ISSUE if FIFO not empty, else -> IDLE.
  - HALT (feature only): terminal until reset.
- Operand stability: the write master captures operands up to several cycles after dma_init, so dma_address/dma_data must not change from ISSUE until the next ISSUE.
- Issue spacing: back-to-back requests need ≥3 cycles between dma_init pulses (ISSUE, done detect, cooldown release).
- dma_done already high in WAIT_DONE's first cycle counts as completion.
- completed_count increments exactly once per dma_done rising interval.

Optional Feature:
- Macro: DMA_SEQ_TIMEOUT_EN.
- When defined:
  - 32-bit watchdog counter cleared on ISSUE, incremented each WAIT_DONE cycle.
  - On reaching TIMEOUT_CYCLES without dma_done: timeout_error<=1 (sticky) and state -> HALT.
  - HALT: no further dma_init; FIFO still accepts pushes until full; busy=1.
  - Only reset clears HALT and timeout_error.
- When undefined: no counter logic; timeout_error tied 0; WAIT_DONE waits indefinitely.

Test Plan:
- Single request: push addr 0x43C00000, data 0xDEADBEEF; model asserts dma_done 4 cycles after dma_init for 2 cycles -> one dma_init pulse, operands stable throughout, completed_count=1, busy falls after dma_done drops.
- Burst: push 16 entries back-to-back (FIFO_DEPTH=16) -> in_ready drops after 16th push; all 16 issued in order with matching addr/data; completed_count=16; fifo_level returns to 0.
- Done-level hold: model keeps dma_done high 10 cycles -> no second dma_init until dma_done low; count incremented once per write.
- Simultaneous push/pop: push on the same cycle as ISSUE with level 3 -> level stays 3; ordering preserved.
- Reset mid-write: assert reset during WAIT_DONE with 5 queued -> all outputs to reset values; no dma_init while stale dma_done high; new request issues correctly afterwards.
- Timeout (DMA_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=20): never assert dma_done -> timeout_error=1 at 20 cycles after ISSUE, no further dma_init, busy=1 until reset.
